path_tracer: RTL and testbench

//   Back-tracks the solved cost/direction field produced by the node execution units.

---
 rtl/path_tracer.sv | 189 ++++++++++++++++++
 tb/tb_path_tracer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_tracer.sv
//------------------------------------------------------------------------------
// path_tracer : walks a solved cost/direction field back from a destination to
//               the source and streams the visited cells out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module path_tracer #(
  parameter int COLS      = 16,
  parameter int ROWS      = 16,
  parameter int XW        = 4,
  parameter int YW        = 4,
  parameter int MAX_STEPS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] dst_x,
  input  logic [YW-1:0] dst_y,
  output logic          busy,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [11:0]   rd_cost,
  input  logic [2:0]    rd_dir,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [XW-1:0] step_x,
  output logic [YW-1:0] step_y,
  output logic [2:0]    step_dir,
  output logic          step_last,
  output logic          done,
  output logic [1:0]    status,
  output logic [15:0]   step_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EVAL = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_UNREACH = 2'd1;
  localparam logic [1:0]  ST_BOUNDS  = 2'd2;
  localparam logic [1:0]  ST_OVERRUN = 2'd3;
  localparam logic [11:0] COST_INF   = 12'hFFF;
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  state_t        state;
  logic [XW-1:0] cur_x, next_x;
  logic [YW-1:0] cur_y, next_y;

  int            dx, dy, nx, ny;
  logic          next_oob;
  logic          dst_oob;
  logic [XW-1:0] nx_c;
  logic [YW-1:0] ny_c;

  // Neighbour addressed by the direction just read; signed so edges never wrap.
  always_comb begin
    dx = 0;
    dy = 0;
    case (rd_dir)
      3'd0: begin dx =  0; dy = -1; end
      3'd1: begin dx =  1; dy = -1; end
      3'd2: begin dx =  1; dy =  0; end
      3'd3: begin dx =  1; dy =  1; end
      3'd4: begin dx =  0; dy =  1; end
      3'd5: begin dx = -1; dy =  1; end
      3'd6: begin dx = -1; dy =  0; end
      default: begin dx = -1; dy = -1; end
    endcase
    nx       = int'(cur_x) + dx;
    ny       = int'(cur_y) + dy;
    next_oob = (nx < 0) || (nx >= COLS) || (ny < 0) || (ny >= ROWS);
    nx_c     = nx[XW-1:0];
    ny_c     = ny[YW-1:0];
    dst_oob  = (int'(dst_x) >= COLS) || (int'(dst_y) >= ROWS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      next_x     <= '0;
      next_y     <= '0;
      busy       <= 1'b0;
      rd_en      <= 1'b0;
      rd_x       <= '0;
      rd_y       <= '0;
      step_valid <= 1'b0;
      step_x     <= '0;
      step_y     <= '0;
      step_dir   <= '0;
      step_last  <= 1'b0;
      done       <= 1'b0;
      status     <= ST_OK;
      step_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_x      <= dst_x;
            cur_y      <= dst_y;
            step_count <= '0;
            busy       <= 1'b1;
            if (dst_oob) begin
              status <= ST_BOUNDS;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              status <= ST_OK;
              rd_en  <= 1'b1;
              rd_x   <= dst_x;
              rd_y   <= dst_y;
              state  <= S_RD;
            end
          end
        end
        S_RD: begin
          rd_en <= 1'b0;
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (rd_cost == COST_INF) begin
            status <= ST_UNREACH;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (step_count == STEP_LIMIT) begin
            status <= ST_OVERRUN;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (rd_cost == 12'd0) begin
            step_valid <= 1'b1;
            step_x     <= cur_x;
            step_y     <= cur_y;
            step_dir   <= 3'd0;
            step_last  <= 1'b1;
            state      <= S_EMIT;
          end else if (next_oob) begin
            status <= ST_BOUNDS;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            step_valid <= 1'b1;
            step_x     <= cur_x;
            step_y     <= cur_y;
            step_dir   <= rd_dir;
            step_last  <= 1'b0;
            next_x     <= nx_c;
            next_y     <= ny_c;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (step_ready) begin
            step_valid <= 1'b0;
            if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
            if (step_last) begin
              status <= ST_OK;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              cur_x <= next_x;
              cur_y <= next_y;
              rd_en <= 1'b1;
              rd_x  <= next_x;
              rd_y  <= next_y;
              state <= S_RD;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_path_tracer.sv
//------------------------------------------------------------------------------
// tb_path_tracer : directed and randomized traces against a queue-based model.
// Revision       : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_path_tracer;

  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int MAXS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  dst_x = '0;
  logic [3:0]  dst_y = '0;
  logic        busy, rd_en, step_valid, step_last, done;
  logic [3:0]  rd_x, rd_y, step_x, step_y;
  logic [11:0] rd_cost = '0;
  logic [2:0]  rd_dir = '0;
  logic        step_ready = 1'b0;
  logic [2:0]  step_dir;
  logic [1:0]  status;
  logic [15:0] step_count;

  path_tracer #(.COLS(COLS), .ROWS(ROWS), .XW(4), .YW(4), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_x(dst_x), .dst_y(dst_y),
    .busy(busy), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cost(rd_cost), .rd_dir(rd_dir),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_x(step_x), .step_y(step_y), .step_dir(step_dir), .step_last(step_last),
    .done(done), .status(status), .step_count(step_count)
  );

  always #5 clk = ~clk;

  logic [11:0] cost_mem [COLS*ROWS];
  logic [2:0]  dir_mem  [COLS*ROWS];
  int          reads;

  // Field memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_cost <= cost_mem[int'(rd_y)*COLS + int'(rd_x)];
      rd_dir  <= dir_mem[int'(rd_y)*COLS + int'(rd_x)];
      reads   <= reads + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int exp_x[$], exp_y[$], exp_d[$], exp_l[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_field();
    for (int i = 0; i < COLS*ROWS; i++) begin
      cost_mem[i] = 12'hFFF;
      dir_mem[i]  = 3'd0;
    end
  endtask

  task automatic set_cell(input int x, input int y, input int c, input int d);
    cost_mem[y*COLS + x] = 12'(c);
    dir_mem[y*COLS + x]  = 3'(d);
  endtask

  // Follow the field by its rules; returns final status, step count, read count.
  task automatic model(input int x0, input int y0, output int st, output int n, output int nrd);
    int x, y, c, d, nx, ny;
    exp_x.delete(); exp_y.delete(); exp_d.delete(); exp_l.delete();
    x = x0; y = y0; n = 0; nrd = 0; st = 0;
    forever begin
      c = int'(cost_mem[y*COLS + x]);
      d = int'(dir_mem[y*COLS + x]);
      nrd++;
      if (c == 12'hFFF) begin st = 1; break; end
      if (n == MAXS) begin st = 3; break; end
      if (c == 0) begin
        exp_x.push_back(x); exp_y.push_back(y); exp_d.push_back(0); exp_l.push_back(1);
        n++; st = 0; break;
      end
      nx = x + dxt[d]; ny = y + dyt[d];
      if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin st = 2; break; end
      exp_x.push_back(x); exp_y.push_back(y); exp_d.push_back(d); exp_l.push_back(0);
      n++; x = nx; y = ny;
    end
  endtask

  // mode 0: ready high, 1: ready low 5 cycles per step, 2: random ready
  task automatic run_trace(input string name, input int sx, input int sy, input int mode);
    int est, en, enrd, idx, hold, cyc;
    logic r, got_done, stall;
    logic [3:0] sv_x, sv_y;
    logic [2:0] sv_d;
    logic sv_l;
    model(sx, sy, est, en, enrd);
    @(negedge clk);
    reads = 0;
    start = 1'b1; dst_x = 4'(sx); dst_y = 4'(sy);
    step_ready = (mode == 0);
    idx = 0; hold = 0; got_done = 1'b0; stall = 1'b0;
    sv_x = '0; sv_y = '0; sv_d = '0; sv_l = 1'b0;
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check({name, "_busy_after_start"}, busy, 1);
      start = 1'b0;
      if (stall) begin
        if (step_valid !== 1'b1 || step_x !== sv_x || step_y !== sv_y ||
            step_dir !== sv_d || step_last !== sv_l)
          check({name, "_stall_stable"}, {step_valid, step_x, step_y, step_dir, step_last},
                {1'b1, sv_x, sv_y, sv_d, sv_l});
      end
      if (done) begin got_done = 1'b1; break; end
      if (cyc == 2) begin start = 1'b1; dst_x = 4'd0; dst_y = 4'd0; end
      case (mode)
        0: r = 1'b1;
        1: begin
          if (step_valid && hold < 5) begin r = 1'b0; hold++; end
          else r = step_valid;
        end
        default: r = 1'($urandom_range(0, 1));
      endcase
      step_ready = r;
      if (step_valid && r) begin
        hold = 0;
        if (idx < en) begin
          if (step_x !== 4'(exp_x[idx]) || step_y !== 4'(exp_y[idx]) ||
              step_dir !== 3'(exp_d[idx]) || step_last !== 1'(exp_l[idx]) || idx < 3)
            check({name, "_step"}, {step_x, step_y, step_dir, step_last},
                  {4'(exp_x[idx]), 4'(exp_y[idx]), 3'(exp_d[idx]), 1'(exp_l[idx])});
        end else begin
          check({name, "_extra_step"}, idx, en);
        end
        idx++;
      end
      stall = step_valid && !r;
      sv_x = step_x; sv_y = step_y; sv_d = step_dir; sv_l = step_last;
    end
    start = 1'b0;
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_status"}, status, est);
    check({name, "_step_count"}, step_count, en);
    check({name, "_steps_taken"}, idx, en);
    check({name, "_reads"}, reads, enrd);
    check({name, "_busy_in_done"}, busy, 1);
    @(negedge clk);
    check({name, "_idle_busy"}, {busy, done, step_valid}, 0);
    step_ready = 1'b0;
  endtask

  task automatic random_field();
    int x, y, len, d, nx, ny;
    for (int i = 0; i < COLS*ROWS; i++) begin
      cost_mem[i] = ($urandom_range(0, 4) == 0) ? 12'hFFF : 12'($urandom_range(1, 200));
      dir_mem[i]  = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic random_trace(input int t);
    int x, y, x0, y0, len, d, nx, ny;
    random_field();
    x = $urandom_range(0, COLS-1); y = $urandom_range(0, ROWS-1);
    x0 = x; y0 = y;
    len = $urandom_range(0, 20);
    for (int i = 0; i < len; i++) begin
      do begin
        d = $urandom_range(0, 7);
        nx = x + dxt[d]; ny = y + dyt[d];
      end while (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS);
      set_cell(x, y, len - i, d);
      x = nx; y = ny;
    end
    if ($urandom_range(0, 5) != 0) set_cell(x, y, 0, 0);
    run_trace($sformatf("rand%0d", t), x0, y0, t % 3);
  endtask

  initial begin
    int saw_done;
    logic found;
    clear_field();
    reads = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, rd_en, rd_x, rd_y, step_valid, step_x, step_y, step_dir,
                            step_last, done, status, step_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, rd_en, step_valid, done, status, step_count}, 0);

    // straight west run to a source at the origin
    clear_field();
    set_cell(0, 0, 0, 0);
    for (int x = 1; x <= 3; x++) set_cell(x, 0, x, 6);
    run_trace("west", 3, 0, 0);
    run_trace("west_bp", 3, 0, 1);

    clear_field();
    set_cell(0, 0, 0, 0);
    set_cell(1, 1, 1, 7);
    set_cell(2, 2, 2, 7);
    run_trace("diag", 2, 2, 0);

    clear_field();
    run_trace("unreach", 4, 4, 0);

    clear_field();
    set_cell(7, 9, 0, 0);
    run_trace("at_source", 7, 9, 2);

    clear_field();
    set_cell(0, 5, 5, 6);
    run_trace("bounds", 0, 5, 0);

    clear_field();
    set_cell(15, 15, 3, 3);
    run_trace("bounds_se", 15, 15, 0);

    clear_field();
    set_cell(5, 5, 9, 2);
    set_cell(6, 5, 9, 6);
    run_trace("overrun", 5, 5, 0);

    for (int t = 0; t < 12; t++) random_trace(t);

    // reset while a record is waiting in EMIT
    clear_field();
    set_cell(0, 0, 0, 0);
    for (int x = 1; x <= 3; x++) set_cell(x, 0, x, 6);
    @(negedge clk);
    step_ready = 1'b0;
    start = 1'b1; dst_x = 4'd3; dst_y = 4'd0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (step_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_emit_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_emit_cleared", {step_valid, busy, done, step_count, status}, 0);
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("rst_emit_no_done", saw_done, 0);

    run_trace("after_rst", 3, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
